// File: rtl/vrased_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vrased_pkg
//  Purpose  : Shared types and constants for the VRASED violation-reset
//             sequencer (state encoding, default reset vector).
//  Revision : 1.0 - initial release
// ============================================================================
package vrased_pkg;

    // Sequencer states. ASSERT is the reset-driving state and is also the
    // state entered from rst.
    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        WAIT   = 2'd1,
        RUN    = 2'd2
    } state_e;

    // Default CPU reset vector.
    localparam logic [15:0] C_RESET_HANDLER_DEFAULT = 16'h0000;

endpackage : vrased_pkg
`default_nettype wire

// File: rtl/vrased_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module   : vrased_hold_timer
//  Purpose  : Reloadable down-counter with a zero flag. It times the minimum
//             width of the system reset pulse.
//  Ports    : clk     - clock
//             rst     - synchronous active-high reset (loads START_VAL)
//             i_load  - reload the counter with START_VAL
//             i_dec   - decrement by one (stops at zero)
//             o_zero  - counter is zero
//  Revision : 1.0 - initial release
// ============================================================================
module vrased_hold_timer #(
    parameter int START_VAL = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int c_W = (START_VAL > 1) ? $clog2(START_VAL + 1) : 1;
    localparam logic [c_W-1:0] c_START = c_W'(START_VAL);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_START;
        end else if (i_load) begin
            r_count <= c_START;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule : vrased_hold_timer
`default_nettype wire

// File: rtl/vrased_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vrased_reset_seq
//  Purpose  : Merges per-monitor violation requests into one registered
//             system reset of guaranteed minimum width. After the pulse, the
//             CPU must reach the reset handler before normal run resumes.
//             An optional debug log records sticky causes and a saturating
//             count of reset events.
//  Macro    : VRASED_VIOL_LOG_EN - when defined, cause / viol_cnt are
//             implemented; otherwise both are tied to zero and cause_clr is
//             ignored. Sequencing is identical in both builds.
//  Ports    : clk          - clock
//             rst          - synchronous active-high reset
//             viol         - per-monitor reset requests (level, active-high)
//             pc           - CPU program counter
//             cause_clr    - clear strobe for cause / viol_cnt
//             sys_reset    - registered system reset (high in ASSERT)
//             in_recovery  - registered, high in ASSERT and WAIT
//             cause        - sticky causes, bit N_SRC = handler timeout
//             viol_cnt     - saturating reset-event count
//  Revision : 1.0 - initial release
// ============================================================================
module vrased_reset_seq
    import vrased_pkg::*;
#(
    parameter int          N_SRC         = 4,
    parameter int          HOLD_CYCLES   = 16,
    parameter int          WAIT_TIMEOUT  = 64,
    parameter logic [15:0] RESET_HANDLER = C_RESET_HANDLER_DEFAULT,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] viol,
    input  logic [15:0]      pc,
    input  logic             cause_clr,
    output logic             sys_reset,
    output logic             in_recovery,
    output logic [N_SRC:0]   cause,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int c_WCNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_MAX = c_WCNT_W'(WAIT_TIMEOUT - 1);

    state_e              r_state;
    state_e              w_next_state;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_WCNT_W-1:0] w_wcnt_next;
    logic                r_sys_reset;
    logic                r_in_recovery;
    logic                w_any_viol;
    logic                w_hold_load;
    logic                w_hold_dec;
    logic                w_hold_zero;
    logic                w_event;    // new reset event (entry into ASSERT)
    logic                w_timeout;  // handler not reached in time

    assign w_any_viol = |viol;

    vrased_hold_timer #(
        .START_VAL (HOLD_CYCLES - 1)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_hold_load),
        .i_dec  (w_hold_dec),
        .o_zero (w_hold_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ASSERT;
            r_wcnt        <= '0;
            r_sys_reset   <= 1'b1;
            r_in_recovery <= 1'b1;
        end else begin
            r_state       <= w_next_state;
            r_wcnt        <= w_wcnt_next;
            // Outputs are registered from the next state so they line up
            // exactly with the state register.
            r_sys_reset   <= (w_next_state == ASSERT);
            r_in_recovery <= (w_next_state != RUN);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wcnt_next  = r_wcnt;
        w_hold_load  = 1'b0;
        w_hold_dec   = 1'b0;
        w_event      = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_any_viol) begin
                    w_next_state = ASSERT;
                    w_hold_load  = 1'b1;
                    w_event      = 1'b1;
                end
            end
            ASSERT: begin
                // A request held during ASSERT stretches the pulse but is
                // the same event, so it is not counted again.
                if (w_any_viol) begin
                    w_hold_load = 1'b1;
                end else if (w_hold_zero) begin
                    w_next_state = WAIT;
                    w_wcnt_next  = '0;
                end else begin
                    w_hold_dec = 1'b1;
                end
            end
            WAIT: begin
                if (w_any_viol) begin
                    w_next_state = ASSERT;
                    w_hold_load  = 1'b1;
                    w_event      = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    w_next_state = RUN;
                end else if (r_wcnt == c_WCNT_MAX) begin
                    w_next_state = ASSERT;
                    w_hold_load  = 1'b1;
                    w_event      = 1'b1;
                    w_timeout    = 1'b1;
                end else begin
                    w_wcnt_next = r_wcnt + c_WCNT_W'(1);
                end
            end
            default: begin
                w_next_state = ASSERT;
                w_hold_load  = 1'b1;
            end
        endcase
    end

    assign sys_reset   = r_sys_reset;
    assign in_recovery = r_in_recovery;

`ifdef VRASED_VIOL_LOG_EN
    logic [N_SRC:0]   r_cause;
    logic [CNT_W-1:0] r_viol_cnt;
    logic [N_SRC:0]   w_cause_base;
    logic [CNT_W-1:0] w_cnt_base;

    // Clear first, then OR in this cycle's causes so a set wins over clear.
    always_comb begin
        w_cause_base = cause_clr ? '0 : r_cause;
        w_cnt_base   = cause_clr ? '0 : r_viol_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause    <= '0;
            r_viol_cnt <= '0;
        end else begin
            r_cause <= w_cause_base | {w_timeout, viol};
            if (w_event && (w_cnt_base != {CNT_W{1'b1}})) begin
                r_viol_cnt <= w_cnt_base + CNT_W'(1);
            end else begin
                r_viol_cnt <= w_cnt_base;
            end
        end
    end

    assign cause    = r_cause;
    assign viol_cnt = r_viol_cnt;
`else
    logic w_unused;
    assign w_unused = ^{cause_clr, w_event, w_timeout};
    assign cause    = '0;
    assign viol_cnt = '0;
`endif

endmodule : vrased_reset_seq
`default_nettype wire
